// File: rtl/multicycle_mcu.sv
// rtl/multicycle_mcu.sv - multi-cycle MIPS main control FSM; perf counters when MCU_PERF_CNT_EN is defined
module multicycle_mcu #(
    parameter int RA_ADDR = 31,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       instr,
    input  logic             protect,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             ALUSrc1,
    output logic             ExtOp,
    output logic [1:0]       ALUOP,
    output logic [1:0]       ALUSrc2,
    output logic [1:0]       RegDst,
    output logic [1:0]       PCSource,
    output logic [4:0]       WAddr,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [3:0]       state
`ifdef MCU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ORIEX  = 4'd10;
    localparam logic [3:0] S_ORIWB  = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    // Counter only needs to reach TIMEOUT-1: the abort fires on the TIMEOUT-th wait cycle.
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [3:0]     state_q, state_d, ready_next;
    logic [WCW-1:0] wait_cnt, wait_d;
    logic           tmo_d, is_wait, timeout_hit, retire_evt;
    logic           pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write;
    logic           mem_to_reg, reg_write, alu_src1, ext_op, illegal;
    logic [1:0]     alu_op, alu_src2, reg_dst, pc_source;

    assign timeout_hit = (TIMEOUT != 0) && (int'(wait_cnt) == TIMEOUT - 1);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src1      = 1'b0;
        ext_op        = 1'b0;
        illegal       = 1'b0;
        alu_op        = 2'b00;
        alu_src2      = 2'b00;
        reg_dst       = 2'b00;
        pc_source     = 2'b00;
        state_d       = state_q;
        ready_next    = S_FETCH;
        is_wait       = 1'b0;
        retire_evt    = 1'b0;
        tmo_d         = 1'b0;
        wait_d        = wait_cnt;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src2   = 2'b01;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                is_wait    = 1'b1;
                ready_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src2 = 2'b11;
                ext_op   = 1'b1;
                case (instr)
                    OP_R:         state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ORI:       state_d = S_ORIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src1 = 1'b1;
                alu_src2 = 2'b10;
                ext_op   = 1'b1;
                state_d  = (instr == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                mem_read   = 1'b1;
                is_wait    = 1'b1;
                ready_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
                retire_evt = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                is_wait    = 1'b1;
                ready_next = S_FETCH;
                retire_evt = mem_ready;
            end
            S_EXEC: begin
                alu_src1 = 1'b1;
                alu_op   = 2'b10;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
                retire_evt = 1'b1;
            end
            S_BRANCH: begin
                alu_src1      = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = S_FETCH;
                retire_evt    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                state_d    = S_FETCH;
                retire_evt = 1'b1;
            end
            S_ORIEX: begin
                alu_src1 = 1'b1;
                alu_src2 = 2'b10;
                alu_op   = 2'b11;
                state_d  = S_ORIWB;
            end
            S_ORIWB: begin
                reg_write  = 1'b1;
                state_d    = S_FETCH;
                retire_evt = 1'b1;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                state_d    = S_FETCH;
                retire_evt = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // A ready on the same edge as the timeout completes the access normally.
        if (is_wait) begin
            if (mem_ready) begin
                state_d = ready_next;
            end else if (timeout_hit) begin
                state_d = S_FETCH;
                tmo_d   = 1'b1;
            end
        end
        if ((state_d != state_q) || tmo_d) begin
            wait_d = '0;
        end else if (is_wait) begin
            wait_d = wait_cnt + WCW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (protect) begin
            mem_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt    <= wait_d;
            mem_timeout <= tmo_d;
        end
    end

`ifdef MCU_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire_evt && !protect) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
    logic unused_retire;
    assign unused_retire = retire_evt;
`endif

    assign PCWrite     = pc_write & ~protect;
    assign PCWriteCond = pc_write_cond & ~protect;
    assign IorD        = iord & ~protect;
    assign IRWrite     = ir_write & ~protect;
    assign MemRead     = mem_read & ~protect;
    assign MemWrite    = mem_write & ~protect;
    assign MemToReg    = mem_to_reg & ~protect;
    assign RegWrite    = reg_write & ~protect;
    assign ALUSrc1     = alu_src1 & ~protect;
    assign ExtOp       = ext_op & ~protect;
    assign ALUOP       = protect ? 2'b00 : alu_op;
    assign ALUSrc2     = protect ? 2'b00 : alu_src2;
    assign RegDst      = protect ? 2'b00 : reg_dst;
    assign PCSource    = protect ? 2'b00 : pc_source;
    assign WAddr       = ((state_q == S_JAL) && !protect) ? 5'(RA_ADDR) : 5'd0;
    assign illegal_op  = illegal & ~protect;
    assign mem_req     = MemRead | MemWrite;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_mcu.sv
// tb/tb_multicycle_mcu.sv - self-checking bench for multicycle_mcu against a path/table model
module tb_multicycle_mcu;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 32;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    typedef struct packed {
        logic       pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write;
        logic       mem_to_reg, reg_write, alu_src1, ext_op;
        logic [1:0] alu_op, alu_src2, reg_dst, pc_source;
        logic [4:0] waddr;
        logic       illegal, mem_req;
    } ctrl_t;

    logic clk = 1'b0;
    logic reset, protect, mem_ready;
    logic [5:0] instr;
    logic mem_req, PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg;
    logic RegWrite, ALUSrc1, ExtOp, illegal_op, mem_timeout;
    logic [1:0] ALUOP, ALUSrc2, RegDst, PCSource;
    logic [4:0] WAddr;
    logic [3:0] state;
`ifdef MCU_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt, retire_cnt;
`endif

    int  checks = 0;
    int  failures = 0;
    int  cycle_exp = 0;
    int  retire_exp = 0;
    logic pend_tmo = 1'b0;
    logic [5:0] ops [8] = '{OP_R, OP_BEQ, OP_ORI, OP_LW, OP_SW, OP_J, OP_JAL, 6'h3f};

    always #5 clk = ~clk;

    multicycle_mcu #(.RA_ADDR(31), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr(instr), .protect(protect), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .ALUSrc1(ALUSrc1), .ExtOp(ExtOp), .ALUOP(ALUOP),
        .ALUSrc2(ALUSrc2), .RegDst(RegDst), .PCSource(PCSource), .WAddr(WAddr),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
`ifdef MCU_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
    );

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_BEQ, OP_ORI, OP_LW, OP_SW, OP_J, OP_JAL};
    endfunction

    // Control table: one row per state, straight from the state descriptions.
    function automatic ctrl_t exp_ctrl(input int st, input logic rdy, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.mem_read = 1; c.alu_src2 = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            1:  begin c.alu_src2 = 2'b11; c.ext_op = 1; c.illegal = !is_legal(op); end
            2:  begin c.alu_src1 = 1; c.alu_src2 = 2'b10; c.ext_op = 1; end
            3:  begin c.iord = 1; c.mem_read = 1; end
            4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
            5:  begin c.iord = 1; c.mem_write = 1; end
            6:  begin c.alu_src1 = 1; c.alu_op = 2'b10; end
            7:  begin c.reg_dst = 2'b01; c.reg_write = 1; end
            8:  begin c.alu_src1 = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
            10: begin c.alu_src1 = 1; c.alu_src2 = 2'b10; c.alu_op = 2'b11; end
            11: begin c.reg_write = 1; end
            12: begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1; c.reg_dst = 2'b10; c.waddr = 5'd31; end
            default: ;
        endcase
        c.mem_req = c.mem_read | c.mem_write;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset) cycle_exp++;
        pend_tmo = 1'b0;
        #1;
    endtask

    task automatic check(input string tag, input int exp_st, input ctrl_t exp_c, input logic exp_tmo);
        ctrl_t o;
        o = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegWrite, ALUSrc1,
             ExtOp, ALUOP, ALUSrc2, RegDst, PCSource, WAddr, illegal_op, mem_req};
        checks++;
        assert (state === 4'(exp_st)) else begin
            failures++; $error("FAIL %s state got=%0d exp=%0d", tag, state, exp_st);
        end
        checks++;
        assert (o === exp_c) else begin
            failures++; $error("FAIL %s ctrl got=%h exp=%h (state %0d)", tag, o, exp_c, exp_st);
        end
        checks++;
        assert (mem_timeout === exp_tmo) else begin
            failures++; $error("FAIL %s mem_timeout got=%b exp=%b", tag, mem_timeout, exp_tmo);
        end
`ifdef MCU_PERF_CNT_EN
        checks++;
        assert (cycle_cnt === CNT_W'(cycle_exp)) else begin
            failures++; $error("FAIL %s cycle_cnt got=%0d exp=%0d", tag, cycle_cnt, cycle_exp);
        end
        checks++;
        assert (retire_cnt === CNT_W'(retire_exp)) else begin
            failures++; $error("FAIL %s retire_cnt got=%0d exp=%0d", tag, retire_cnt, retire_exp);
        end
`endif
    endtask

    // Builds the expected state path for one instruction, then drives and checks it cycle by cycle.
    // mw >= TIMEOUT means the data access never completes and must be aborted.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input int prot_st, input int prot_len, input logic prot_rdy);
        int   st_q[$];
        logic rdy_q[$];
        bit   timed_out, prot_done;
        int   mst, n;
        timed_out = 0;
        prot_done = 0;
        for (int i = 0; i < fw; i++) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
        st_q.push_back(0); rdy_q.push_back(1'b1);
        st_q.push_back(1); rdy_q.push_back(1'($urandom));
        case (op)
            OP_R:   begin st_q.push_back(6);  st_q.push_back(7);  rdy_q.push_back(1'b1); rdy_q.push_back(1'b0); end
            OP_ORI: begin st_q.push_back(10); st_q.push_back(11); rdy_q.push_back(1'b0); rdy_q.push_back(1'b1); end
            OP_BEQ: begin st_q.push_back(8);  rdy_q.push_back(1'($urandom)); end
            OP_J:   begin st_q.push_back(9);  rdy_q.push_back(1'($urandom)); end
            OP_JAL: begin st_q.push_back(12); rdy_q.push_back(1'($urandom)); end
            OP_LW, OP_SW: begin
                mst = (op == OP_LW) ? 3 : 5;
                st_q.push_back(2); rdy_q.push_back(1'($urandom));
                n = (mw >= TIMEOUT) ? TIMEOUT : mw;
                for (int i = 0; i < n; i++) begin st_q.push_back(mst); rdy_q.push_back(1'b0); end
                if (mw >= TIMEOUT) begin
                    timed_out = 1;
                end else begin
                    st_q.push_back(mst); rdy_q.push_back(1'b1);
                    if (op == OP_LW) begin st_q.push_back(4); rdy_q.push_back(1'($urandom)); end
                end
            end
            default: ;
        endcase
        for (int k = 0; k < st_q.size(); k++) begin
            if (!prot_done && st_q[k] == prot_st) begin
                prot_done = 1;
                for (int p = 0; p < prot_len; p++) begin
                    instr = op; protect = 1'b1; mem_ready = prot_rdy; #1;
                    check($sformatf("op%02h_prot%0d", op, p), st_q[k], '0, pend_tmo);
                    step();
                end
                protect = 1'b0;
            end
            instr = op; mem_ready = rdy_q[k]; #1;
            check($sformatf("op%02h_c%0d", op, k), st_q[k], exp_ctrl(st_q[k], rdy_q[k], op), pend_tmo);
            step();
        end
        if (timed_out) pend_tmo = 1'b1;
        else if (is_legal(op)) retire_exp++;
    endtask

    initial begin
        reset = 1'b1; protect = 1'b1; mem_ready = 1'b0; instr = '0;
        step();
        check("reset_protect", 0, '0, 1'b0);
        protect = 1'b0; #1;
        check("reset_fetch", 0, exp_ctrl(0, 1'b0, '0), 1'b0);
        step();
        reset = 1'b0;

        run_instr(OP_ORI, 0, 0, -1, 0, 1'b0);
        run_instr(OP_LW,  0, 3, -1, 0, 1'b0);
        run_instr(OP_JAL, 0, 0, -1, 0, 1'b0);
        run_instr(6'h3f,  0, 0, -1, 0, 1'b0);
        run_instr(OP_R,   0, 0,  6, 5, 1'b1);
        run_instr(OP_LW,  1, 0,  3, 2, 1'b1);
        run_instr(OP_SW,  0, TIMEOUT, -1, 0, 1'b0);
        run_instr(OP_BEQ, 0, 0, -1, 0, 1'b0);
        run_instr(OP_SW,  0, TIMEOUT - 1, -1, 0, 1'b0);
        run_instr(OP_LW,  2, TIMEOUT, -1, 0, 1'b0);
        run_instr(OP_J,   0, 0,  0, 3, 1'b1);
        run_instr(OP_SW,  0, 2, -1, 0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            logic [5:0] op;
            int fw, mw, ps, pl;
            op = ops[$urandom_range(0, 7)];
            fw = $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 4);
            ps = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : -1;
            pl = $urandom_range(1, 3);
            run_instr(op, fw, mw, ps, pl, 1'($urandom));
        end
        run_instr(OP_J, 0, 0, -1, 0, 1'b0);

        // Asynchronous reset in the middle of a load must drop straight back to FETCH.
        instr = OP_LW; mem_ready = 1'b1; #1;
        check("ar_fetch", 0, exp_ctrl(0, 1'b1, OP_LW), 1'b0);
        step();
        mem_ready = 1'b0; #1;
        check("ar_decode", 1, exp_ctrl(1, 1'b0, OP_LW), 1'b0);
        step(); #1;
        check("ar_memadr", 2, exp_ctrl(2, 1'b0, OP_LW), 1'b0);
        step(); #1;
        check("ar_memrd", 3, exp_ctrl(3, 1'b0, OP_LW), 1'b0);
        #1 reset = 1'b1; #1;
        cycle_exp = 0; retire_exp = 0; pend_tmo = 1'b0;
        check("ar_reset", 0, exp_ctrl(0, 1'b0, OP_LW), 1'b0);
        step();
        reset = 1'b0;
        run_instr(OP_ORI, 0, 0, -1, 0, 1'b0);
        run_instr(OP_R,   1, 0, -1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
